// File: rtl/mgmt_qspi_pkg.sv
// Shared opcodes, frame sizes and FSM state encoding for the management QSPI host.
package mgmt_qspi_pkg;

  localparam logic [7:0] OP_WRITE = 8'h02;
  localparam logic [7:0] OP_READ  = 8'h0B;

  localparam int unsigned ADDR_NIBBLES = 6;
  localparam int unsigned DATA_NIBBLES = 4;

  typedef enum logic [3:0] {
    IDLE,
    CS_SETUP,
    OPCODE,
    ADDR,
    WDATA,
    TURNAROUND,
    RDATA,
    CS_HOLD,
    CS_IDLE
  } qspi_host_state_t;

endpackage

// File: rtl/mgmt_qspi_sck_gen.sv
// SCK generator: toggles every CLK_DIV clk cycles while enabled, with
// combinational strobes marking the clk edge on which SCK rises or falls.
module mgmt_qspi_sck_gen #(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_en,
  output logic o_sck,
  output logic o_rise,
  output logic o_fall
);

  localparam int unsigned PW = $clog2(CLK_DIV + 1);
  localparam logic [PW-1:0] PHASE_LAST = PW'(CLK_DIV - 1);

  logic [PW-1:0] r_phase;
  logic          r_sck;
  logic          w_edge;

  always_comb begin
    w_edge = i_en && (r_phase == PHASE_LAST);
    o_rise = w_edge && !r_sck;
    o_fall = w_edge && r_sck;
    o_sck  = r_sck;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_phase <= '0;
      r_sck   <= 1'b0;
    end else if (!i_en) begin
      r_phase <= '0;
      r_sck   <= 1'b0;
    end else if (w_edge) begin
      r_phase <= '0;
      r_sck   <= ~r_sck;
    end else begin
      r_phase <= r_phase + 1'b1;
    end
  end

endmodule

// File: rtl/mgmt_qspi_host.sv
// Quad-SPI host: serialises single-word read/write requests as opcode,
// address, optional dummy cycles and data, in SPI mode 0.
module mgmt_qspi_host
  import mgmt_qspi_pkg::*;
#(
  parameter int unsigned CLK_DIV        = 2,
  parameter int unsigned DUMMY_CYCLES   = 4,
  parameter int unsigned CS_IDLE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [23:0] req_addr,
  input  logic [15:0] req_wdata,
  output logic        rsp_valid,
  output logic [15:0] rsp_rdata,
  output logic        qspi_sck,
  output logic        qspi_cs_n,
  output logic [3:0]  qspi_dq_out,
  output logic        qspi_dq_oe,
  input  logic [3:0]  qspi_dq_in
);

  localparam int unsigned WAIT_MAX = (CLK_DIV > CS_IDLE_CYCLES) ? CLK_DIV : CS_IDLE_CYCLES;
  localparam int unsigned WW = $clog2(WAIT_MAX + 1);
  localparam int unsigned DW = (DUMMY_CYCLES > 0) ? $clog2(DUMMY_CYCLES + 1) : 1;
  localparam logic [WW-1:0] HOLD_LAST  = WW'(CLK_DIV - 1);
  localparam logic [WW-1:0] IDLE_LAST  = WW'(CS_IDLE_CYCLES - 1);
  localparam logic [DW-1:0] DUMMY_LAST = DW'(DUMMY_CYCLES - 1);

  qspi_host_state_t r_state;
  logic [WW-1:0]    r_wait;
  logic [3:0]       r_nib;
  logic [DW-1:0]    r_dummy;
  logic             r_write;
  logic [43:0]      r_tx;
  logic [15:0]      r_rx;
  logic             r_cs_n, r_oe, r_ready, r_rsp_valid;
  logic [3:0]       r_dq_out;
  logic [15:0]      r_rsp_rdata;

  logic       w_sck_en, w_sck, w_rise, w_fall, w_idle_done;
  logic [7:0] w_op;

  always_comb begin
    w_sck_en    = r_state inside {CS_SETUP, OPCODE, ADDR, WDATA, TURNAROUND, RDATA};
    w_op        = req_write ? OP_WRITE : OP_READ;
    w_idle_done = (CS_IDLE_CYCLES == 0) || (r_wait == IDLE_LAST);
  end

  mgmt_qspi_sck_gen #(.CLK_DIV(CLK_DIV)) u_sck_gen (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_en   (w_sck_en),
    .o_sck  (w_sck),
    .o_rise (w_rise),
    .o_fall (w_fall)
  );

  assign qspi_sck    = w_sck;
  assign qspi_cs_n   = r_cs_n;
  assign qspi_dq_oe  = r_oe;
  assign qspi_dq_out = r_dq_out;
  assign req_ready   = r_ready;
  assign rsp_valid   = r_rsp_valid;
  assign rsp_rdata   = r_rsp_rdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_wait      <= '0;
      r_nib       <= '0;
      r_dummy     <= '0;
      r_write     <= 1'b0;
      r_tx        <= '0;
      r_rx        <= '0;
      r_cs_n      <= 1'b1;
      r_oe        <= 1'b0;
      r_ready     <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_dq_out    <= '0;
      r_rsp_rdata <= '0;
    end else begin
      r_rsp_valid <= 1'b0;
      unique case (r_state)
        // Out of reset the CS idle window is timed here before ready rises.
        IDLE: begin
          if (!r_ready) begin
            if (w_idle_done) begin
              r_ready <= 1'b1;
              r_wait  <= '0;
            end else begin
              r_wait <= r_wait + 1'b1;
            end
          end else if (req_valid) begin
            r_ready  <= 1'b0;
            r_write  <= req_write;
            r_cs_n   <= 1'b0;
            r_oe     <= 1'b1;
            r_dq_out <= w_op[7:4];
            r_tx     <= {w_op[3:0], req_addr, req_wdata};
            r_rx     <= '0;
            r_nib    <= '0;
            r_dummy  <= '0;
            r_state  <= CS_SETUP;
          end
        end
        CS_SETUP: if (w_rise) r_state <= OPCODE;
        OPCODE: if (w_fall) begin
          r_dq_out <= r_tx[43:40];
          r_tx     <= {r_tx[39:0], 4'h0};
          if (r_nib == 4'd1) begin
            r_nib   <= '0;
            r_state <= ADDR;
          end else begin
            r_nib <= r_nib + 4'd1;
          end
        end
        ADDR: if (w_fall) begin
          if (r_nib == 4'(ADDR_NIBBLES - 1)) begin
            r_nib <= '0;
            if (r_write) begin
              r_dq_out <= r_tx[43:40];
              r_tx     <= {r_tx[39:0], 4'h0};
              r_state  <= WDATA;
            end else begin
              r_oe     <= 1'b0;
              r_dq_out <= '0;
              r_state  <= (DUMMY_CYCLES > 0) ? TURNAROUND : RDATA;
            end
          end else begin
            r_dq_out <= r_tx[43:40];
            r_tx     <= {r_tx[39:0], 4'h0};
            r_nib    <= r_nib + 4'd1;
          end
        end
        WDATA: if (w_fall) begin
          if (r_nib == 4'(DATA_NIBBLES - 1)) begin
            r_dq_out <= '0;
            r_wait   <= '0;
            r_state  <= CS_HOLD;
          end else begin
            r_dq_out <= r_tx[43:40];
            r_tx     <= {r_tx[39:0], 4'h0};
            r_nib    <= r_nib + 4'd1;
          end
        end
        TURNAROUND: if (w_fall) begin
          if (r_dummy == DUMMY_LAST) begin
            r_dummy <= '0;
            r_state <= RDATA;
          end else begin
            r_dummy <= r_dummy + 1'b1;
          end
        end
        RDATA: begin
          if (w_rise) r_rx <= {r_rx[11:0], qspi_dq_in};
          if (w_fall) begin
            if (r_nib == 4'(DATA_NIBBLES - 1)) begin
              r_wait  <= '0;
              r_state <= CS_HOLD;
            end else begin
              r_nib <= r_nib + 4'd1;
            end
          end
        end
        CS_HOLD: begin
          if (r_wait == HOLD_LAST) begin
            r_cs_n      <= 1'b1;
            r_oe        <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_rsp_rdata <= r_write ? 16'h0000 : r_rx;
            r_wait      <= '0;
            if (CS_IDLE_CYCLES == 0) begin
              r_ready <= 1'b1;
              r_state <= IDLE;
            end else begin
              r_state <= CS_IDLE;
            end
          end else begin
            r_wait <= r_wait + 1'b1;
          end
        end
        CS_IDLE: begin
          if (r_wait == IDLE_LAST) begin
            r_ready <= 1'b1;
            r_wait  <= '0;
            r_state <= IDLE;
          end else begin
            r_wait <= r_wait + 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mgmt_qspi_host.sv
// Directed bench for mgmt_qspi_host: three instances (CLK_DIV 2/1/5) with a
// bus-level device model sampling on the clk falling edge.
module tb_mgmt_qspi_host;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid [3];
  logic        req_ready [3];
  logic        req_write [3];
  logic [23:0] req_addr  [3];
  logic [15:0] req_wdata [3];
  logic        rsp_valid [3];
  logic [15:0] rsp_rdata [3];
  logic        qspi_sck  [3];
  logic        qspi_cs_n [3];
  logic [3:0]  qspi_dq_out [3];
  logic        qspi_dq_oe  [3];
  logic [3:0]  qspi_dq_in  [3];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    mgmt_qspi_host #(
      .CLK_DIV        (g == 0 ? 2 : (g == 1 ? 1 : 5)),
      .DUMMY_CYCLES   (g == 0 ? 4 : 0),
      .CS_IDLE_CYCLES (4)
    ) u_dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .req_valid   (req_valid[g]),
      .req_ready   (req_ready[g]),
      .req_write   (req_write[g]),
      .req_addr    (req_addr[g]),
      .req_wdata   (req_wdata[g]),
      .rsp_valid   (rsp_valid[g]),
      .rsp_rdata   (rsp_rdata[g]),
      .qspi_sck    (qspi_sck[g]),
      .qspi_cs_n   (qspi_cs_n[g]),
      .qspi_dq_out (qspi_dq_out[g]),
      .qspi_dq_oe  (qspi_dq_oe[g]),
      .qspi_dq_in  (qspi_dq_in[g])
    );
  end

  // Device model / monitor state, written only by the monitor process.
  bit          prev_sck [3], prev_cs [3], prev_oe [3];
  int          t_rises [3], t_falls [3], t_ncap [3], t_oe_drop [3], run [3];
  int          hi_min [3], hi_max [3], lo_min [3], lo_max [3];
  bit [47:0]   t_cap [3];
  int          n_rsp [3], n_acc [3], n_cs [3], cshi_run [3], cshi_w [3], gap [3];
  logic [15:0] last_rdata [3];
  logic [15:0] m_rdword [3];

  int checks = 0;
  int failures = 0;

  always @(negedge clk) begin
    int d, idx;
    for (int g = 0; g < 3; g++) begin
      d = (g == 0) ? 4 : 0;
      if (qspi_cs_n[g]) cshi_run[g]++;
      if (req_valid[g] && req_ready[g]) begin
        n_acc[g]++;
        gap[g] = cshi_run[g];
      end
      if (rsp_valid[g]) begin
        n_rsp[g]++;
        last_rdata[g] = rsp_rdata[g];
      end
      if (!qspi_cs_n[g] && prev_cs[g]) begin
        n_cs[g]++;
        cshi_w[g] = cshi_run[g];
        cshi_run[g] = 0;
        t_rises[g] = 0; t_falls[g] = 0; t_ncap[g] = 0; t_cap[g] = '0;
        t_oe_drop[g] = -1; run[g] = 0;
        hi_min[g] = 999; hi_max[g] = 0; lo_min[g] = 999; lo_max[g] = 0;
      end
      if (!qspi_cs_n[g]) begin
        if (qspi_sck[g] && !prev_sck[g]) begin
          t_rises[g]++;
          if (qspi_dq_oe[g]) begin
            t_ncap[g]++;
            t_cap[g] = {t_cap[g][43:0], qspi_dq_out[g]};
          end
          if (run[g] < lo_min[g]) lo_min[g] = run[g];
          if (run[g] > lo_max[g]) lo_max[g] = run[g];
          run[g] = 1;
        end else if (!qspi_sck[g] && prev_sck[g]) begin
          t_falls[g]++;
          if (run[g] < hi_min[g]) hi_min[g] = run[g];
          if (run[g] > hi_max[g]) hi_max[g] = run[g];
          run[g] = 1;
          if (t_falls[g] >= 8 + d && t_falls[g] < 12 + d) begin
            idx = t_falls[g] - (8 + d);
            qspi_dq_in[g] = 4'(m_rdword[g] >> (12 - 4 * idx));
          end
        end else begin
          run[g]++;
        end
        if (prev_oe[g] && !qspi_dq_oe[g]) t_oe_drop[g] = t_rises[g];
      end else begin
        qspi_dq_in[g] = 4'h0;
      end
      prev_sck[g] = qspi_sck[g];
      prev_cs[g]  = qspi_cs_n[g];
      prev_oe[g]  = qspi_dq_oe[g];
    end
  end

  task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic start_req(input int g, input logic wr, input logic [23:0] a, input logic [15:0] wd);
    int k = 0;
    while (!req_ready[g] && k < 500) begin
      step(1);
      k++;
    end
    chk("ready_timeout", 48'(req_ready[g]), 48'd1);
    req_write[g] = wr;
    req_addr[g]  = a;
    req_wdata[g] = wd;
    req_valid[g] = 1'b1;
    step(1);
    req_valid[g] = 1'b0;
  endtask

  task automatic wait_rsp(input int g, input int base);
    int k = 0;
    while (n_rsp[g] == base && k < 2000) begin
      step(1);
      k++;
    end
    chk("rsp_timeout", 48'(n_rsp[g] != base), 48'd1);
  endtask

  initial begin
    int b_rsp, b_acc, b_cs, k;
    rst_n = 1'b0;
    for (int g = 0; g < 3; g++) begin
      req_valid[g] = 1'b0; req_write[g] = 1'b0;
      req_addr[g] = '0; req_wdata[g] = '0; m_rdword[g] = '0;
    end
    step(3);
    chk("rst_cs_n", 48'(qspi_cs_n[0]), 48'd1);
    chk("rst_sck", 48'(qspi_sck[0]), 48'd0);
    chk("rst_oe", 48'(qspi_dq_oe[0]), 48'd0);
    chk("rst_dq_out", 48'(qspi_dq_out[0]), 48'd0);
    chk("rst_ready", 48'(req_ready[0]), 48'd0);
    chk("rst_rsp_valid", 48'(rsp_valid[0]), 48'd0);
    chk("rst_rsp_rdata", 48'(rsp_rdata[0]), 48'd0);
    rst_n = 1'b1;
    step(3);
    chk("post_rst_ready_early", 48'(req_ready[0]), 48'd0);
    step(1);
    chk("post_rst_ready", 48'(req_ready[0]), 48'd1);

    // Write, CLK_DIV=2
    b_rsp = n_rsp[0];
    start_req(0, 1'b1, 24'h009010, 16'hBEEF);
    chk("wr_ready_drop", 48'(req_ready[0]), 48'd0);
    chk("wr_cs_low", 48'(qspi_cs_n[0]), 48'd0);
    wait_rsp(0, b_rsp);
    step(10);
    chk("wr_rises", 48'(t_rises[0]), 48'd12);
    chk("wr_falls", 48'(t_falls[0]), 48'd12);
    chk("wr_ncap", 48'(t_ncap[0]), 48'd12);
    chk("wr_nibbles", t_cap[0], 48'h020090_10BEEF);
    chk("wr_rsp_count", 48'(n_rsp[0] - b_rsp), 48'd1);
    chk("wr_rsp_rdata", 48'(last_rdata[0]), 48'd0);
    chk("wr_hi_min", 48'(hi_min[0]), 48'd2);
    chk("wr_hi_max", 48'(hi_max[0]), 48'd2);
    chk("wr_lo_min", 48'(lo_min[0]), 48'd2);
    chk("wr_lo_max", 48'(lo_max[0]), 48'd2);

    // Read, CLK_DIV=2, 4 dummy cycles
    m_rdword[0] = 16'h1234;
    b_rsp = n_rsp[0];
    start_req(0, 1'b0, 24'h00A002, 16'h0000);
    wait_rsp(0, b_rsp);
    step(2);
    chk("rd_rises", 48'(t_rises[0]), 48'd16);
    chk("rd_falls", 48'(t_falls[0]), 48'd16);
    chk("rd_oe_drop", 48'(t_oe_drop[0]), 48'd8);
    chk("rd_ncap", 48'(t_ncap[0]), 48'd8);
    chk("rd_nibbles", t_cap[0], 48'h0B00A002);
    chk("rd_rdata", 48'(last_rdata[0]), 48'h1234);

    // Back-to-back with req_valid held
    b_rsp = n_rsp[0];
    b_acc = n_acc[0];
    req_write[0] = 1'b1; req_addr[0] = 24'h000001; req_wdata[0] = 16'h0001;
    req_valid[0] = 1'b1;
    k = 0;
    while (n_acc[0] < b_acc + 2 && k < 3000) begin
      step(1);
      k++;
    end
    req_valid[0] = 1'b0;
    chk("b2b_accept_timeout", 48'(n_acc[0] - b_acc), 48'd2);
    wait_rsp(0, b_rsp + 1);
    step(10);
    chk("b2b_gap_ge4", 48'(gap[0] >= 4), 48'd1);
    chk("b2b_cs_high_ge4", 48'(cshi_w[0] >= 4), 48'd1);
    chk("b2b_rsp_count", 48'(n_rsp[0] - b_rsp), 48'd2);

    // req_valid pulsed while busy
    b_rsp = n_rsp[0]; b_acc = n_acc[0]; b_cs = n_cs[0];
    start_req(0, 1'b1, 24'h0A0B0C, 16'h5555);
    step(10);
    req_write[0] = 1'b0; req_valid[0] = 1'b1;
    step(1);
    req_valid[0] = 1'b0;
    wait_rsp(0, b_rsp);
    step(30);
    chk("busy_acc_count", 48'(n_acc[0] - b_acc), 48'd1);
    chk("busy_cs_count", 48'(n_cs[0] - b_cs), 48'd1);
    chk("busy_rsp_count", 48'(n_rsp[0] - b_rsp), 48'd1);
    chk("busy_nibbles", t_cap[0], 48'h020A0B0C5555);

    // CLK_DIV=1, no dummy cycles
    m_rdword[1] = 16'hA5C3;
    b_rsp = n_rsp[1];
    start_req(1, 1'b0, 24'h123456, 16'h0000);
    wait_rsp(1, b_rsp);
    step(2);
    chk("d1_rises", 48'(t_rises[1]), 48'd12);
    chk("d1_oe_drop", 48'(t_oe_drop[1]), 48'd8);
    chk("d1_nibbles", t_cap[1], 48'h0B123456);
    chk("d1_rdata", 48'(last_rdata[1]), 48'hA5C3);
    chk("d1_hi_min", 48'(hi_min[1]), 48'd1);
    chk("d1_hi_max", 48'(hi_max[1]), 48'd1);
    chk("d1_lo_min", 48'(lo_min[1]), 48'd1);
    chk("d1_lo_max", 48'(lo_max[1]), 48'd1);

    // CLK_DIV=5, no dummy cycles
    m_rdword[2] = 16'h0F71;
    b_rsp = n_rsp[2];
    start_req(2, 1'b0, 24'hFEDCBA, 16'h0000);
    wait_rsp(2, b_rsp);
    step(2);
    chk("d5_rises", 48'(t_rises[2]), 48'd12);
    chk("d5_oe_drop", 48'(t_oe_drop[2]), 48'd8);
    chk("d5_rdata", 48'(last_rdata[2]), 48'h0F71);
    chk("d5_hi_min", 48'(hi_min[2]), 48'd5);
    chk("d5_hi_max", 48'(hi_max[2]), 48'd5);
    chk("d5_lo_min", 48'(lo_min[2]), 48'd5);
    chk("d5_lo_max", 48'(lo_max[2]), 48'd5);

    // Reset asserted mid-ADDR
    start_req(0, 1'b1, 24'h123456, 16'h7777);
    k = 0;
    while (t_rises[0] < 4 && k < 200) begin
      step(1);
      k++;
    end
    chk("mid_addr_reached", 48'(t_rises[0] >= 4 && !qspi_cs_n[0]), 48'd1);
    b_rsp = n_rsp[0];
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_cs_n", 48'(qspi_cs_n[0]), 48'd1);
    chk("mid_rst_oe", 48'(qspi_dq_oe[0]), 48'd0);
    chk("mid_rst_sck", 48'(qspi_sck[0]), 48'd0);
    step(2);
    rst_n = 1'b1;
    step(3);
    chk("mid_rst_ready_early", 48'(req_ready[0]), 48'd0);
    step(1);
    chk("mid_rst_ready", 48'(req_ready[0]), 48'd1);
    step(20);
    chk("mid_rst_no_rsp", 48'(n_rsp[0] - b_rsp), 48'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mgmt_qspi_host.md
Name: mgmt_qspi_host

Overview:
- Quad-SPI host controller that drives the QSPI device-side management bridge from a supervisor or test harness.
- Takes single-word read/write requests (24-bit byte address, 16-bit data) on a valid/ready interface and serialises them as opcode, address, optional dummy cycles, then data.
- Returns read data on a one-cycle response strobe.
- Sits in front of the pad tristate logic; the bidirectional DQ pins are split into out/oe/in here.

Parameters:
- CLK_DIV, 2: SCK half-period in clk cycles; legal range 1..255.
- DUMMY_CYCLES, 4: SCK cycles of turnaround between address and read data.
- CS_IDLE_CYCLES, 4: minimum clk cycles CS stays high between transactions.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  host idle, accepts request
- req_write  in  1  1=write, 0=read
- req_addr  in  24  byte address
- req_wdata  in  16  write data
- rsp_valid  out  1  one-cycle pulse at transaction end (reads and writes)
- rsp_rdata  out  16  read data, valid with rsp_valid (0 for writes)
- qspi_sck  out  1  serial clock
- qspi_cs_n  out  1  chip select, active low
- qspi_dq_out  out  4  DQ drive value
- qspi_dq_oe  out  1  DQ output enable
- qspi_dq_in  in  4  DQ sampled value

Behaviour:
- Reset (async assert, release synchronous to clk):
  - qspi_cs_n=1, qspi_sck=0, qspi_dq_oe=0, qspi_dq_out=0.
  - req_ready=0 until CS_IDLE_CYCLES have elapsed, then 1.
  - rsp_valid=0, rsp_rdata=0, state IDLE.
- Handshake:
  - A request is accepted on the clk edge where req_valid && req_ready.
  - req_* are latched on that edge; req_ready drops the same edge and stays low until the CS idle window after the transaction completes.
- SPI mode 0:
  - SCK idles low.
  - The host changes DQ on SCK falling edges (and at CS assertion).
  - The host samples qspi_dq_in on SCK rising edges.
  - Each SCK phase lasts CLK_DIV clk cycles. All nibbles are MSB-first.
- State sequence:
  - IDLE: wait for accept.
  - CS_SETUP: CS low, first opcode nibble driven, oe=1; lasts CLK_DIV cycles.
  - OPCODE: 2 SCK cycles. Opcodes are OP_WRITE=8'h02 and OP_READ=8'h0B.
  - ADDR: 6 SCK cycles, addr[23:20] first.
  - Writes: WDATA, 4 SCK cycles, wdata[15:12] first, then CS_HOLD.
  - Reads: TURNAROUND. oe drops at the falling edge ending the last address cycle, followed by DUMMY_CYCLES SCK cycles. Then RDATA: 4 SCK cycles, each rising edge shifts qspi_dq_in into rdata from the LSB side, so the first nibble ends up in [15:12].
  - CS_HOLD: SCK low for CLK_DIV cycles, then CS high, oe=0. rsp_valid pulses on the same clk edge CS rises; rsp_rdata updates there and holds until the next rsp_valid.
  - CS_IDLE: CS_IDLE_CYCLES clk cycles, then IDLE with req_ready=1.
- SCK cycle counts per transaction: writes 12; reads 12+DUMMY_CYCLES. DUMMY_CYCLES=0 is legal (RDATA directly follows ADDR; oe still drops at the last address falling edge).
- Counters:
  - phase counter width is clog2(CLK_DIV+1).
  - nibble counter is 4 bits.
  - dummy counter width is clog2(DUMMY_CYCLES+1).
  - All counters saturate or reload; none wrap silently.
- req_valid asserted while busy is ignored; no queueing.
- Reset mid-transaction: CS rises immediately (asynchronous) and no rsp_valid is issued.

Decomposition:
- Package mgmt_qspi_pkg holds:
  - OP_WRITE, OP_READ;
  - the state enum qspi_host_state_t (IDLE, CS_SETUP, OPCODE, ADDR, WDATA, TURNAROUND, RDATA, CS_HOLD, CS_IDLE);
  - ADDR_NIBBLES=6 and DATA_NIBBLES=4.
- One sub-module, mgmt_qspi_sck_gen: produces SCK plus one-cycle rise/fall strobes from CLK_DIV, gated by an enable. The FSM advances on those strobes.

Test Plan:
- CLK_DIV=2, write addr=24'h009010 data=16'hBEEF:
  - nibbles seen by a bench device model on rising edges are 0,2,0,0,9,0,1,0,B,E,E,F;
  - exactly 12 SCK cycles;
  - rsp_valid pulses once with rsp_rdata=0.
- Read addr=24'h00A002, DUMMY_CYCLES=4, model drives 16'h1234 after the turnaround:
  - oe falls after the 8th SCK cycle;
  - 16 SCK cycles total;
  - rsp_rdata=16'h1234 at rsp_valid.
- Back-to-back requests with req_valid held high:
  - second accept occurs ≥ CS_IDLE_CYCLES (4) clk after CS rises;
  - CS high width ≥ 4 clk.
- CLK_DIV=1 and CLK_DIV=5, DUMMY_CYCLES=0:
  - SCK high/low widths are 1 and 5 clk respectively;
  - read data is correct;
  - RDATA immediately follows ADDR.
- rst_n asserted mid-ADDR:
  - same-cycle CS=1, oe=0, SCK=0, no rsp_valid;
  - req_ready returns 1 after 4 clk following reset release.
- req_valid pulsed while busy:
  - ignored, with no extra transaction on the bus.
